// File: rtl/cdc_push_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_push_arbiter
//
// Purpose:
//   Shares the single write port of a clock-domain-crossing FIFO among
//   NUM_REQ requesters that all live in the write-clock domain. Each requester
//   drives a valid/ready stream of beats, and the last beat of a packet is
//   flagged with req_last. One requester owns the FIFO write port at a time.
//   Ownership is held until that requester's last beat has been pushed, so
//   packets are never interleaved on the crossing. Ownership is handed out
//   round-robin.
//
//   A packet that runs MAX_BEATS beats without a last flag is forcibly
//   released. The sticky len_err flag records that this happened. The rest of
//   that packet then competes again as a fresh packet.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   DATA_WIDTH - payload width, must match the FIFO
//   MAX_BEATS  - packet-length limit before a forced release (1..255)
//
// Ports:
//   ACLK        in   write-domain clock
//   ARESETn     in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]             per-requester beat valid
//   req_last    in   [NUM_REQ]             per-requester final-beat flag
//   req_data    in   [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   out  [NUM_REQ]             per-requester beat accepted
//   fifo_wfull  in                         FIFO full flag
//   fifo_wpush  out                        FIFO push strobe
//   fifo_wdata  out  [DATA_WIDTH]          FIFO write data
//   grant_id    out  [clog2(NUM_REQ)]      current owner, valid while busy
//   busy        out                        a requester currently owns the port
//   len_err     out                        sticky forced-release flag
// -----------------------------------------------------------------------------
module cdc_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 37,
  parameter int MAX_BEATS  = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_wfull,
  output logic                            fifo_wpush,
  output logic [DATA_WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            len_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Registered state
  state_t          r_state;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_last_grant;
  logic [7:0]      r_beat_cnt;
  logic            r_len_err;

  // Next-state values
  state_t          w_next_state;
  logic [ID_W-1:0] w_next_owner;
  logic [ID_W-1:0] w_next_last_grant;
  logic [7:0]      w_next_beat_cnt;
  logic            w_next_len_err;

  // Round-robin search result
  logic            w_rr_found;
  logic [ID_W-1:0] w_rr_idx;

  // Current owner's stream, selected from the flat request buses
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic [DATA_WIDTH-1:0] w_owner_data;

  logic w_in_grant;
  logic w_accept;
  logic w_limit_hit;

  // Round-robin search. The scan starts one past the previous winner and
  // wraps, so the previous winner is considered last. The first valid index
  // met on the way is taken.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_rr_found && req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Owner stream mux. This is written as a compare loop instead of a variable
  // part-select, which keeps the index arithmetic at the natural width.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == r_owner) begin
        w_owner_valid = req_valid[i];
        w_owner_last  = req_last[i];
        w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_in_grant  = (r_state == S_GRANT);
  assign w_accept    = w_in_grant & w_owner_valid & ~fifo_wfull;
  assign w_limit_hit = ((r_beat_cnt + 8'd1) == 8'(MAX_BEATS));

  // The write-port outputs are purely combinational from the state/owner
  // registers and the live valid/full inputs. This lets a beat go into the
  // FIFO in the same cycle that it is offered. Outside GRANT, everything is
  // forced to zero. An asynchronous reset therefore kills an in-flight push
  // at once.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_in_grant & (ID_W'(i) == r_owner) & ~fifo_wfull;
    end
  end

  assign fifo_wpush = w_accept;
  assign fifo_wdata = w_in_grant ? w_owner_data : '0;

  assign grant_id = r_owner;
  assign busy     = w_in_grant;
  assign len_err  = r_len_err;

  // Next-state logic. fifo_wfull only gates w_accept. It never moves the FSM
  // by itself. If an owner drops valid mid-packet, the FSM simply stays in
  // GRANT, and only reset recovers it.
  always_comb begin
    w_next_state      = r_state;
    w_next_owner      = r_owner;
    w_next_last_grant = r_last_grant;
    w_next_beat_cnt   = r_beat_cnt;
    w_next_len_err    = r_len_err;

    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_next_state      = S_GRANT;
          w_next_owner      = w_rr_idx;
          w_next_last_grant = w_rr_idx;
          w_next_beat_cnt   = 8'd0;
        end
      end

      S_GRANT: begin
        if (w_accept) begin
          w_next_beat_cnt = r_beat_cnt + 8'd1;
          if (w_owner_last) begin
            w_next_state = S_IDLE;
          end else if (w_limit_hit) begin
            // Forced release. The remaining beats re-arbitrate as a new packet.
            w_next_state   = S_IDLE;
            w_next_len_err = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register. At reset, last_grant is set to the top index, so
  // requester 0 is first in line after reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_beat_cnt   <= 8'd0;
      r_len_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_owner      <= w_next_owner;
      r_last_grant <= w_next_last_grant;
      r_beat_cnt   <= w_next_beat_cnt;
      r_len_err    <= w_next_len_err;
    end
  end

endmodule

// File: tb/tb_cdc_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_push_arbiter
//
// Purpose:
//   Directed bench for cdc_push_arbiter. It uses two instances that share the
//   same stimulus:
//     dut  - default parameters (MAX_BEATS = 16)
//     dutL - MAX_BEATS = 4, for exercising the forced-release path
//   Inputs are driven 1 time unit after the rising edge. Outputs are compared
//   1 time unit after that, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_cdc_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 37;

  logic            aclk;
  logic            aresetn;
  logic [NR-1:0]   reqValid;
  logic [NR-1:0]   reqLast;
  logic [NR*DW-1:0] reqData;
  logic            fifoWfull;

  logic [NR-1:0]   reqReady;
  logic            fifoWpush;
  logic [DW-1:0]   fifoWdata;
  logic [1:0]      grantId;
  logic            busy;
  logic            lenErr;

  logic [NR-1:0]   reqReadyL;
  logic            fifoWpushL;
  logic [DW-1:0]   fifoWdataL;
  logic [1:0]      grantIdL;
  logic            busyL;
  logic            lenErrL;

  int numCompared;
  int numMismatched;

  cdc_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(16)) dut (
    .ACLK       (aclk),
    .ARESETn    (aresetn),
    .req_valid  (reqValid),
    .req_last   (reqLast),
    .req_data   (reqData),
    .req_ready  (reqReady),
    .fifo_wfull (fifoWfull),
    .fifo_wpush (fifoWpush),
    .fifo_wdata (fifoWdata),
    .grant_id   (grantId),
    .busy       (busy),
    .len_err    (lenErr)
  );

  cdc_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(4)) dutL (
    .ACLK       (aclk),
    .ARESETn    (aresetn),
    .req_valid  (reqValid),
    .req_last   (reqLast),
    .req_data   (reqData),
    .req_ready  (reqReadyL),
    .fifo_wfull (fifoWfull),
    .fifo_wpush (fifoWpushL),
    .fifo_wdata (fifoWdataL),
    .grant_id   (grantIdL),
    .busy       (busyL),
    .len_err    (lenErrL)
  );

  // 10-unit clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one requester's valid, data and last.
  task automatic applyStimulus(input int idx, input logic v, input logic [DW-1:0] d,
                               input logic l);
    reqValid[idx]           = v;
    reqLast[idx]            = l;
    reqData[idx*DW +: DW]   = d;
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full reset with quiet inputs. This also checks the reset-state outputs.
  // It returns mid-cycle in IDLE, ready for new stimulus.
  task automatic applyReset();
    aresetn   = 1'b0;
    reqValid  = '0;
    reqLast   = '0;
    reqData   = '0;
    fifoWfull = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst busy",     64'(busy),      64'h0);
    checkOutput("rst push",     64'(fifoWpush), 64'h0);
    checkOutput("rst ready",    64'(reqReady),  64'h0);
    checkOutput("rst len_err",  64'(lenErr),    64'h0);
    checkOutput("rst grant_id", 64'(grantId),   64'h0);
    checkOutput("rst wdata",    64'(fifoWdata), 64'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expReady;
    numCompared   = 0;
    numMismatched = 0;

    // ---- Reset, then a 3-beat packet from requester 2 ----
    applyReset();
    applyStimulus(2, 1'b1, 37'h01, 1'b0);
    #1;
    checkOutput("t1 c0 busy", 64'(busy), 64'h0);
    checkOutput("t1 c0 push", 64'(fifoWpush), 64'h0);
    tick(); #1;
    checkOutput("t1 c1 busy",  64'(busy),      64'h1);
    checkOutput("t1 c1 grant", 64'(grantId),   64'h2);
    checkOutput("t1 c1 push",  64'(fifoWpush), 64'h1);
    checkOutput("t1 c1 wdata", 64'(fifoWdata), 64'h01);
    checkOutput("t1 c1 ready", 64'(reqReady),  64'h4);
    tick(); applyStimulus(2, 1'b1, 37'h02, 1'b0); #1;
    checkOutput("t1 c2 push",  64'(fifoWpush), 64'h1);
    checkOutput("t1 c2 wdata", 64'(fifoWdata), 64'h02);
    tick(); applyStimulus(2, 1'b1, 37'h03, 1'b1); #1;
    checkOutput("t1 c3 push",  64'(fifoWpush), 64'h1);
    checkOutput("t1 c3 wdata", 64'(fifoWdata), 64'h03);
    tick(); applyStimulus(2, 1'b0, 37'h0, 1'b0); #1;
    checkOutput("t1 c4 busy", 64'(busy),      64'h0);
    checkOutput("t1 c4 push", 64'(fifoWpush), 64'h0);

    // ---- Round-robin: all four requesters send 1-beat packets continuously ----
    applyReset();
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 37'(32'h100 + i), 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      expReady = 4'(1 << (k % NR));
      tick(); #1;
      checkOutput($sformatf("rr%0d busy", k),  64'(busy),      64'h1);
      checkOutput($sformatf("rr%0d grant", k), 64'(grantId),   64'(k % NR));
      checkOutput($sformatf("rr%0d push", k),  64'(fifoWpush), 64'h1);
      checkOutput($sformatf("rr%0d wdata", k), 64'(fifoWdata), 64'(32'h100 + (k % NR)));
      checkOutput($sformatf("rr%0d ready", k), 64'(reqReady),  64'(expReady));
      tick(); #1;
      checkOutput($sformatf("rr%0d gap busy", k),  64'(busy),      64'h0);
      checkOutput($sformatf("rr%0d gap push", k),  64'(fifoWpush), 64'h0);
      checkOutput($sformatf("rr%0d gap ready", k), 64'(reqReady),  64'h0);
    end
    reqValid = '0;
    reqLast  = '0;
    #1;

    // ---- Backpressure: requester 1, 4 beats, FIFO full in cycles 2..4 ----
    applyStimulus(1, 1'b1, 37'h11, 1'b0);
    #1;
    tick(); #1;
    checkOutput("bp c1 grant", 64'(grantId),   64'h1);
    checkOutput("bp c1 push",  64'(fifoWpush), 64'h1);
    checkOutput("bp c1 wdata", 64'(fifoWdata), 64'h11);
    for (int c = 2; c <= 4; c++) begin
      tick();
      applyStimulus(1, 1'b1, 37'h12, 1'b0);
      fifoWfull = 1'b1;
      #1;
      checkOutput($sformatf("bp c%0d push", c),  64'(fifoWpush), 64'h0);
      checkOutput($sformatf("bp c%0d ready", c), 64'(reqReady),  64'h0);
      checkOutput($sformatf("bp c%0d busy", c),  64'(busy),      64'h1);
      checkOutput($sformatf("bp c%0d grant", c), 64'(grantId),   64'h1);
      checkOutput($sformatf("bp c%0d wdata", c), 64'(fifoWdata), 64'h12);
    end
    tick(); fifoWfull = 1'b0; #1;
    checkOutput("bp c5 push",  64'(fifoWpush), 64'h1);
    checkOutput("bp c5 wdata", 64'(fifoWdata), 64'h12);
    checkOutput("bp c5 ready", 64'(reqReady),  64'h2);
    tick(); applyStimulus(1, 1'b1, 37'h13, 1'b0); #1;
    checkOutput("bp c6 wdata", 64'(fifoWdata), 64'h13);
    checkOutput("bp c6 grant", 64'(grantId),   64'h1);
    tick(); applyStimulus(1, 1'b1, 37'h14, 1'b1); #1;
    checkOutput("bp c7 push",  64'(fifoWpush), 64'h1);
    checkOutput("bp c7 wdata", 64'(fifoWdata), 64'h14);
    tick(); applyStimulus(1, 1'b0, 37'h0, 1'b0); #1;
    checkOutput("bp c8 busy", 64'(busy), 64'h0);

    // ---- Packet lock: requester 3 sends 5 beats, requester 0 joins at beat 2 ----
    applyStimulus(3, 1'b1, 37'h31, 1'b0);
    #1;
    for (int b = 1; b <= 5; b++) begin
      tick();
      applyStimulus(3, 1'b1, 37'(48 + b), (b == 5));
      if (b == 2) applyStimulus(0, 1'b1, 37'h0A, 1'b1);
      #1;
      checkOutput($sformatf("pl b%0d grant", b), 64'(grantId),   64'h3);
      checkOutput($sformatf("pl b%0d push", b),  64'(fifoWpush), 64'h1);
      checkOutput($sformatf("pl b%0d wdata", b), 64'(fifoWdata), 64'(48 + b));
      checkOutput($sformatf("pl b%0d ready", b), 64'(reqReady),  64'h8);
    end
    tick(); applyStimulus(3, 1'b0, 37'h0, 1'b0); #1;
    checkOutput("pl gap busy", 64'(busy), 64'h0);
    tick(); #1;
    checkOutput("pl r0 grant", 64'(grantId),   64'h0);
    checkOutput("pl r0 push",  64'(fifoWpush), 64'h1);
    checkOutput("pl r0 wdata", 64'(fifoWdata), 64'h0A);
    tick(); applyStimulus(0, 1'b0, 37'h0, 1'b0); #1;
    checkOutput("pl end busy", 64'(busy), 64'h0);

    // ---- Length limit (dutL, MAX_BEATS = 4): requester 0, 6 beats without last ----
    applyReset();
    applyStimulus(0, 1'b1, 37'h51, 1'b0);
    #1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      applyStimulus(0, 1'b1, 37'(80 + b), 1'b0);
      #1;
      checkOutput($sformatf("ll b%0d busy", b),    64'(busyL),      64'h1);
      checkOutput($sformatf("ll b%0d push", b),    64'(fifoWpushL), 64'h1);
      checkOutput($sformatf("ll b%0d wdata", b),   64'(fifoWdataL), 64'(80 + b));
      checkOutput($sformatf("ll b%0d len_err", b), 64'(lenErrL),    64'h0);
    end
    tick(); applyStimulus(0, 1'b1, 37'h55, 1'b0); #1;
    checkOutput("ll rel busy",    64'(busyL),      64'h0);
    checkOutput("ll rel push",    64'(fifoWpushL), 64'h0);
    checkOutput("ll rel ready",   64'(reqReadyL),  64'h0);
    checkOutput("ll rel len_err", 64'(lenErrL),    64'h1);
    tick(); #1;
    checkOutput("ll b5 grant", 64'(grantIdL),   64'h0);
    checkOutput("ll b5 push",  64'(fifoWpushL), 64'h1);
    checkOutput("ll b5 wdata", 64'(fifoWdataL), 64'h55);
    tick(); applyStimulus(0, 1'b1, 37'h56, 1'b0); #1;
    checkOutput("ll b6 push",  64'(fifoWpushL), 64'h1);
    checkOutput("ll b6 wdata", 64'(fifoWdataL), 64'h56);
    checkOutput("ll b6 len_err", 64'(lenErrL),  64'h1);
    checkOutput("mr dut push before", 64'(fifoWpush), 64'h1);

    // ---- Reset mid-packet: assert reset between edges while beats are in flight ----
    aresetn = 1'b0;
    #1;
    checkOutput("mr push",     64'(fifoWpush),  64'h0);
    checkOutput("mr busy",     64'(busy),       64'h0);
    checkOutput("mr ready",    64'(reqReady),   64'h0);
    checkOutput("mr L push",   64'(fifoWpushL), 64'h0);
    checkOutput("mr L busy",   64'(busyL),      64'h0);
    checkOutput("mr L ready",  64'(reqReadyL),  64'h0);
    checkOutput("mr L len_err", 64'(lenErrL),   64'h0);
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 37'(32'h100 + i), 1'b1);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick(); #1;
    checkOutput("mr prio busy",  64'(busy),      64'h1);
    checkOutput("mr prio grant", 64'(grantId),   64'h0);
    checkOutput("mr prio wdata", 64'(fifoWdata), 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
